// File: rtl/wishbone_arbiter_if.sv
// ---------------------------------------------------------------------------
// wishbone_arbiter_if
// Bundles the N requesting-master buses and the single slave bus that the
// arbiter sits between.
//   m_cyc_i/m_stb_i/m_we_i   per-master request, strobe, write enable
//   m_adr_i/m_dat_i          packed per-master address / write data
//   m_dat_o                  read data broadcast to every master
//   m_ack_o/m_stall_o        per-master acknowledge / stall
//   m_err_o/m_gnt_o          per-master timeout pulse / one-hot grant
//   s_cyc_o..s_dat_o         slave-side request
//   s_dat_i/s_ack_i/s_stall_i slave-side response
// Modport "master" is the arbiter's view (it masters the slave bus).
// Modport "slave" is the complementary view of the surrounding system.
// ---------------------------------------------------------------------------
interface wishbone_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
);
    logic [NUM_MASTERS-1:0]        m_cyc_i;
    logic [NUM_MASTERS-1:0]        m_stb_i;
    logic [NUM_MASTERS-1:0]        m_we_i;
    logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i;
    logic [NUM_MASTERS*DATA_W-1:0] m_dat_i;
    logic [DATA_W-1:0]             m_dat_o;
    logic [NUM_MASTERS-1:0]        m_ack_o;
    logic [NUM_MASTERS-1:0]        m_stall_o;
    logic [NUM_MASTERS-1:0]        m_err_o;
    logic [NUM_MASTERS-1:0]        m_gnt_o;
    logic                          s_cyc_o;
    logic                          s_stb_o;
    logic                          s_we_o;
    logic [ADDR_W-1:0]             s_adr_o;
    logic [DATA_W-1:0]             s_dat_o;
    logic [DATA_W-1:0]             s_dat_i;
    logic                          s_ack_i;
    logic                          s_stall_i;

    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i,
        output m_dat_o, m_ack_o, m_stall_o, m_err_o, m_gnt_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        input  s_dat_i, s_ack_i, s_stall_i
    );

    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i,
        input  m_dat_o, m_ack_o, m_stall_o, m_err_o, m_gnt_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        output s_dat_i, s_ack_i, s_stall_i
    );
endinterface

// File: rtl/wishbone_arbiter.sv
// ---------------------------------------------------------------------------
// wishbone_arbiter
// N-master to 1-slave pipelined Wishbone arbiter with round-robin grant,
// outstanding-beat limiting and a no-ack watchdog.
// Ports:
//   CLK_I  system clock (rising edge)
//   RST_I  asynchronous active-low reset
//   bus    wishbone_arbiter_if.master: all master- and slave-side signals
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no grant; pick next requester round-robin after last_gnt
// BUSY     | granted master drives the slave bus; beats/acks tracked
// ERR_HOLD | watchdog fired; slave bus dropped until master releases cyc
// ---------------------------------------------------------------------------
module wishbone_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 64
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    wishbone_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int WD_W  = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] MAX_OS   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_ERR_HOLD = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_nxt;
    logic [IDX_W-1:0]   r_last_gnt, w_last_gnt_nxt;
    logic [CNT_W-1:0]   r_outstanding, w_outstanding_nxt;
    logic [WD_W-1:0]    r_wdog, w_wdog_nxt;

    logic [IDX_W-1:0]       w_rr_sel;
    logic                   w_rr_found;
    logic                   w_g_cyc, w_g_stb, w_g_we;
    logic [ADDR_W-1:0]      w_g_adr;
    logic [DATA_W-1:0]      w_g_dat;
    logic [NUM_MASTERS-1:0] w_gnt_mask;
    logic                   w_limit, w_timeout, w_stb, w_accept;

    // Round-robin: first scan masters above last_gnt, then wrap to the rest.
    always_comb begin
        w_rr_sel   = r_last_gnt;
        w_rr_found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!w_rr_found && (IDX_W'(k) > r_last_gnt) && bus.m_cyc_i[k]) begin
                w_rr_sel   = IDX_W'(k);
                w_rr_found = 1'b1;
            end
        end
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!w_rr_found && (IDX_W'(k) <= r_last_gnt) && bus.m_cyc_i[k]) begin
                w_rr_sel   = IDX_W'(k);
                w_rr_found = 1'b1;
            end
        end
    end

    // Granted master's request signals.
    always_comb begin
        w_g_cyc = 1'b0;
        w_g_stb = 1'b0;
        w_g_we  = 1'b0;
        w_g_adr = '0;
        w_g_dat = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (IDX_W'(k) == r_gnt_idx) begin
                w_g_cyc = bus.m_cyc_i[k];
                w_g_stb = bus.m_stb_i[k];
                w_g_we  = bus.m_we_i[k];
                w_g_adr = bus.m_adr_i[k*ADDR_W +: ADDR_W];
                w_g_dat = bus.m_dat_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_gnt_mask = NUM_MASTERS'(1) << r_gnt_idx;
    assign w_limit    = (r_outstanding == MAX_OS);
    assign w_timeout  = (r_state == ST_BUSY) && (r_wdog == WD_LAST) &&
                        (r_outstanding != '0);

    always_comb begin
        w_state_nxt       = r_state;
        w_gnt_idx_nxt     = r_gnt_idx;
        w_last_gnt_nxt    = r_last_gnt;
        w_outstanding_nxt = r_outstanding;
        w_wdog_nxt        = r_wdog;
        w_stb             = 1'b0;
        w_accept          = 1'b0;

        bus.m_dat_o   = bus.s_dat_i;
        bus.m_ack_o   = '0;
        bus.m_err_o   = '0;
        bus.m_stall_o = '1;
        bus.m_gnt_o   = '0;
        bus.s_cyc_o   = 1'b0;
        bus.s_stb_o   = 1'b0;
        bus.s_we_o    = w_g_we;
        bus.s_adr_o   = w_g_adr;
        bus.s_dat_o   = w_g_dat;

        case (r_state)
            ST_IDLE: begin
                w_outstanding_nxt = '0;
                w_wdog_nxt        = '0;
                if (w_rr_found) begin
                    w_gnt_idx_nxt = w_rr_sel;
                    w_state_nxt   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                bus.m_gnt_o = w_gnt_mask;
                if (w_timeout) begin
                    // Slave bus dropped this very cycle; acks are not forwarded.
                    bus.m_err_o       = w_gnt_mask;
                    w_state_nxt       = ST_ERR_HOLD;
                    w_outstanding_nxt = '0;
                    w_wdog_nxt        = '0;
                end else begin
                    w_stb         = w_g_cyc & w_g_stb & ~w_limit;
                    w_accept      = w_stb & ~bus.s_stall_i;
                    bus.s_cyc_o   = w_g_cyc;
                    bus.s_stb_o   = w_stb;
                    bus.m_stall_o = ~w_gnt_mask;
                    if (bus.s_stall_i || w_limit) begin
                        bus.m_stall_o = '1;
                    end
                    if (bus.s_ack_i) begin
                        bus.m_ack_o = w_gnt_mask;
                    end

                    if (!w_g_cyc) begin
                        w_state_nxt       = ST_IDLE;
                        w_last_gnt_nxt    = r_gnt_idx;
                        w_outstanding_nxt = '0;
                        w_wdog_nxt        = '0;
                    end else begin
                        // Ack with nothing outstanding is forwarded but not counted.
                        case ({w_accept, bus.s_ack_i})
                            2'b10:   w_outstanding_nxt = r_outstanding + CNT_W'(1);
                            2'b01:   if (r_outstanding != '0)
                                         w_outstanding_nxt = r_outstanding - CNT_W'(1);
                            default: w_outstanding_nxt = r_outstanding;
                        endcase
                        if (bus.s_ack_i || (r_outstanding == '0)) begin
                            w_wdog_nxt = '0;
                        end else begin
                            w_wdog_nxt = r_wdog + WD_W'(1);
                        end
                    end
                end
            end

            ST_ERR_HOLD: begin
                bus.m_gnt_o = w_gnt_mask;
                if (!w_g_cyc) begin
                    w_state_nxt    = ST_IDLE;
                    w_last_gnt_nxt = r_gnt_idx;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state       <= ST_IDLE;
            r_gnt_idx     <= '0;
            r_last_gnt    <= LAST_IDX;
            r_outstanding <= '0;
            r_wdog        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt_idx     <= w_gnt_idx_nxt;
            r_last_gnt    <= w_last_gnt_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_wdog        <= w_wdog_nxt;
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wishbone_arbiter
// Drives two master models and a simple slave model around the arbiter.
// Expected slave-side beats are queued when a burst is set up and popped as
// the slave accepts them.
// ---------------------------------------------------------------------------
module tb_wishbone_arbiter;

    localparam int NM = 2;
    localparam int AW = 8;
    localparam int DW = 8;

    logic CLK_I = 1'b0;
    logic RST_I;

    always #5 CLK_I = ~CLK_I;

    wishbone_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

    wishbone_arbiter #(
        .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW),
        .MAX_OUTSTANDING(4), .TIMEOUT(64)
    ) dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic       mcyc  [NM];
    int         beats [NM];
    logic [7:0] nadr  [NM];
    int         n_ack [NM];
    int         n_err [NM];
    int         n_acc;
    int         ack_pend;
    logic       ack_en, force_ack, slv_stall;
    logic [7:0] rd_val;
    int         cyc_n = 0;
    logic [7:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic push_burst(input logic [7:0] a0, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(a0 + 8'(i));
    endtask

    task automatic tick();
        logic [7:0] e;
        @(negedge CLK_I);
        cyc_n++;
        for (int k = 0; k < NM; k++) begin
            bus.m_cyc_i[k]            = mcyc[k];
            bus.m_stb_i[k]            = mcyc[k] && (beats[k] > 0);
            bus.m_we_i[k]             = nadr[k][0];
            bus.m_adr_i[k*AW +: AW]   = nadr[k];
            bus.m_dat_i[k*DW +: DW]   = nadr[k] ^ 8'hA5;
        end
        rd_val        = 8'(cyc_n) ^ 8'h5A;
        bus.s_dat_i   = rd_val;
        bus.s_stall_i = slv_stall;
        bus.s_ack_i   = force_ack || (ack_en && ack_pend > 0);
        if (bus.s_ack_i && ack_pend > 0) ack_pend--;
        #1;
        if (bus.s_cyc_o && bus.s_stb_o && !bus.s_stall_i) begin
            n_acc++;
            ack_pend++;
            if (exp_q.size() == 0) begin
                check_val("sb_depth", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_val("s_adr", bus.s_adr_o, e);
                check_val("s_dat", bus.s_dat_o, e ^ 8'hA5);
                check_val("s_we",  bus.s_we_o,  e[0]);
            end
        end
        for (int k = 0; k < NM; k++) begin
            if (bus.m_ack_o[k]) n_ack[k]++;
            if (bus.m_err_o[k]) n_err[k]++;
            if (bus.m_cyc_i[k] && bus.m_stb_i[k] && !bus.m_stall_o[k]) begin
                beats[k]--;
                nadr[k]++;
            end
        end
    endtask

    task automatic do_reset();
        RST_I = 1'b0;
        for (int k = 0; k < NM; k++) begin
            mcyc[k] = 1'b0; beats[k] = 0; nadr[k] = '0; n_ack[k] = 0; n_err[k] = 0;
        end
        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
        bus.m_adr_i = '0; bus.m_dat_i = '0;
        bus.s_dat_i = '0; bus.s_ack_i = 1'b0; bus.s_stall_i = 1'b0;
        n_acc = 0; ack_pend = 0; ack_en = 1'b0; force_ack = 1'b0; slv_stall = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b1;
    endtask

    initial begin
        int w, st, a, e;
        logic saw_g1;

        // ---------------- reset values (ack asserted to prove suppression)
        do_reset();
        RST_I = 1'b0;
        bus.m_cyc_i = '1;
        bus.s_ack_i = 1'b1;
        #1;
        check_val("rst_gnt",   bus.m_gnt_o,   2'b00);
        check_val("rst_stall", bus.m_stall_o, 2'b11);
        check_val("rst_scyc",  bus.s_cyc_o,   1'b0);
        check_val("rst_sstb",  bus.s_stb_o,   1'b0);
        check_val("rst_ack",   bus.m_ack_o,   2'b00);
        check_val("rst_err",   bus.m_err_o,   2'b00);

        // ---------------- T1: single master, 3 write/read beats, 1-cycle acks
        do_reset();
        ack_en = 1'b1;
        mcyc[0] = 1'b1; beats[0] = 3; nadr[0] = 8'h10; push_burst(8'h10, 3);
        tick();
        check_val("t1_gnt_idle", bus.m_gnt_o, 2'b00);
        tick();
        check_val("t1_gnt", bus.m_gnt_o, 2'b01);
        for (w = 0; w < 20 && (beats[0] > 0 || n_ack[0] < 3); w++) tick();
        check_val("t1_bound", (w < 20), 1'b1);
        check_val("t1_rdata", bus.m_dat_o, rd_val);
        check_val("t1_acc", n_acc, 3);
        check_val("t1_ack", n_ack[0], 3);
        check_val("t1_q", exp_q.size(), 0);
        mcyc[0] = 1'b0;
        tick();
        check_val("t1_scyc_drop", bus.s_cyc_o, 1'b0);
        tick();
        check_val("t1_idle", bus.m_gnt_o, 2'b00);

        // ---------------- T2: simultaneous requests, round robin, no preemption
        do_reset();
        ack_en = 1'b1;
        mcyc[0] = 1'b1; beats[0] = 1; nadr[0] = 8'h20;
        mcyc[1] = 1'b1; beats[1] = 1; nadr[1] = 8'h30;
        push_burst(8'h20, 1); push_burst(8'h30, 1);
        tick();
        tick();
        check_val("t2_gnt0", bus.m_gnt_o, 2'b01);
        for (w = 0; w < 20 && n_ack[0] < 1; w++) tick();
        check_val("t2_bound0", (w < 20), 1'b1);
        mcyc[0] = 1'b0;
        tick();
        tick();
        check_val("t2_gap", bus.m_gnt_o, 2'b00);
        tick();
        check_val("t2_gnt1", bus.m_gnt_o, 2'b10);
        mcyc[0] = 1'b1; beats[0] = 1; nadr[0] = 8'h28; push_burst(8'h28, 1);
        for (w = 0; w < 20 && n_ack[1] < 1; w++) tick();
        check_val("t2_bound1", (w < 20), 1'b1);
        repeat (3) tick();
        check_val("t2_hold1", bus.m_gnt_o, 2'b10);
        check_val("t2_m0_stall", bus.m_stall_o[0], 1'b1);
        mcyc[1] = 1'b0;
        tick();
        tick();
        check_val("t2_gap2", bus.m_gnt_o, 2'b00);
        tick();
        check_val("t2_gnt0b", bus.m_gnt_o, 2'b01);
        for (w = 0; w < 20 && n_ack[0] < 2; w++) tick();
        check_val("t2_bound2", (w < 20), 1'b1);
        check_val("t2_q", exp_q.size(), 0);
        mcyc[0] = 1'b0;
        tick();

        // ---------------- T3: outstanding limit, one ack reopens one beat
        do_reset();
        mcyc[0] = 1'b1; beats[0] = 8; nadr[0] = 8'h40; push_burst(8'h40, 4);
        repeat (12) tick();
        check_val("t3_acc4", n_acc, 4);
        check_val("t3_stall", bus.m_stall_o[0], 1'b1);
        check_val("t3_sstb", bus.s_stb_o, 1'b0);
        push_burst(8'h44, 1);
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        repeat (5) tick();
        check_val("t3_acc5", n_acc, 5);
        check_val("t3_ack", n_ack[0], 1);
        check_val("t3_stall2", bus.m_stall_o[0], 1'b1);
        mcyc[0] = 1'b0;
        repeat (2) tick();

        // ---------------- T4: slave stall 5 cycles mid-burst
        do_reset();
        ack_en = 1'b1;
        mcyc[0] = 1'b1; beats[0] = 6; nadr[0] = 8'h50; push_burst(8'h50, 6);
        st = 0;
        for (w = 0; w < 60 && (beats[0] > 0 || n_ack[0] < 6); w++) begin
            slv_stall = (n_acc >= 2) && (st < 5);
            tick();
            if (slv_stall) begin
                st++;
                check_val("t4_stall_mirror", bus.m_stall_o[0], 1'b1);
            end
        end
        slv_stall = 1'b0;
        check_val("t4_bound", (w < 60), 1'b1);
        check_val("t4_stalls", st, 5);
        check_val("t4_acc", n_acc, 6);
        check_val("t4_ack", n_ack[0], 6);
        check_val("t4_q", exp_q.size(), 0);
        mcyc[0] = 1'b0;
        tick();

        // ---------------- T5: watchdog timeout with master 1 waiting
        do_reset();
        mcyc[0] = 1'b1; beats[0] = 1; nadr[0] = 8'h60;
        mcyc[1] = 1'b1; beats[1] = 1; nadr[1] = 8'h70;
        push_burst(8'h60, 1); push_burst(8'h70, 1);
        for (w = 0; w < 10 && n_acc == 0; w++) tick();
        check_val("t5_bound_acc", (w < 10), 1'b1);
        a = cyc_n;
        saw_g1 = 1'b0;
        for (w = 0; w < 100 && n_err[0] == 0; w++) begin
            tick();
            if (bus.m_gnt_o[1]) saw_g1 = 1'b1;
        end
        e = cyc_n;
        check_val("t5_bound_err", (w < 100), 1'b1);
        check_val("t5_err_cycle", e - a, 64);
        check_val("t5_scyc_err", bus.s_cyc_o, 1'b0);
        repeat (5) begin
            tick();
            if (bus.m_gnt_o[1]) saw_g1 = 1'b1;
        end
        check_val("t5_err_pulse", n_err[0], 1);
        check_val("t5_no_g1", saw_g1, 1'b0);
        check_val("t5_hold_scyc", bus.s_cyc_o, 1'b0);
        check_val("t5_ack_sup", n_ack[0], 0);
        mcyc[0] = 1'b0; ack_pend = 0; ack_en = 1'b1;
        tick();
        tick();
        check_val("t5_idle", bus.m_gnt_o, 2'b00);
        tick();
        check_val("t5_gnt1", bus.m_gnt_o, 2'b10);
        for (w = 0; w < 20 && n_ack[1] < 1; w++) tick();
        check_val("t5_bound1", (w < 20), 1'b1);
        check_val("t5_q", exp_q.size(), 0);
        mcyc[1] = 1'b0;
        tick();

        // ---------------- T6: async reset mid-burst with 2 outstanding
        do_reset();
        mcyc[0] = 1'b1; beats[0] = 4; nadr[0] = 8'h80; push_burst(8'h80, 4);
        for (w = 0; w < 20 && n_acc < 2; w++) tick();
        check_val("t6_bound", (w < 20), 1'b1);
        bus.s_ack_i = 1'b1;
        RST_I = 1'b0;
        #1;
        check_val("t6_scyc", bus.s_cyc_o, 1'b0);
        check_val("t6_sstb", bus.s_stb_o, 1'b0);
        check_val("t6_gnt", bus.m_gnt_o, 2'b00);
        check_val("t6_stall", bus.m_stall_o, 2'b11);
        check_val("t6_ack", bus.m_ack_o, 2'b00);
        do_reset();
        mcyc[0] = 1'b1; beats[0] = 6; nadr[0] = 8'h90;
        mcyc[1] = 1'b1; beats[1] = 1; nadr[1] = 8'hA0;
        push_burst(8'h90, 4);
        tick();
        tick();
        check_val("t6_gnt0", bus.m_gnt_o, 2'b01);
        repeat (8) tick();
        check_val("t6_acc4", n_acc, 4);
        check_val("t6_limit", bus.m_stall_o[0], 1'b1);
        mcyc[0] = 1'b0; mcyc[1] = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
